// File: rtl/wash_sequencer.sv
// -----------------------------------------------------------------------------
// wash_sequencer
// Washing machine program controller. Walks the machine through fill, wash,
// drain, spin, a configurable number of rinse passes and an end alarm. Each
// phase loads its duration into an external phase timer and waits for the
// timer's expiry pulse before moving on.
//
// Ports
//   i_cp           system clock, rising edge
//   i_clr_n        asynchronous active-low reset
//   i_start        start request, honoured only in IDLE while not paused
//   i_pause        level; high freezes the program in any non-IDLE phase
//   i_qcc          phase timer expiry pulse
//   o_rs[7:0]      timer preset for the current phase
//   o_tclr_n       timer clear, active-low, one-cycle pulse on phase entry
//   o_ten          timer enable; low while idle or paused
//   o_valve_in     inlet valve
//   o_valve_out    drain valve
//   o_motor_en     drum motor on
//   o_motor_dir    drum direction, 0 forward / 1 reverse
//   o_motor_fast   spin speed select
//   o_buzzer       end alarm
//   o_phase[2:0]   current phase code
//   o_rinse_left   rinse passes still to run
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for START; timer and actuators off
// FILL  | inlet valve open
// WASH  | drum turning, direction reversing periodically (wash pass)
// DRAIN | drain valve open
// SPIN  | drain valve open, drum at high speed forward
// RINSE | drum turning, direction reversing periodically (rinse pass)
// DONE  | end alarm sounding
// -----------------------------------------------------------------------------
module wash_sequencer #(
  parameter logic [7:0] T_FILL    = 8'd20,
  parameter logic [7:0] T_WASH    = 8'd90,
  parameter logic [7:0] T_RINSE   = 8'd40,
  parameter logic [7:0] T_DRAIN   = 8'd15,
  parameter logic [7:0] T_SPIN    = 8'd30,
  parameter logic [7:0] T_DONE    = 8'd5,
  parameter logic [1:0] N_RINSE   = 2'd2,
  parameter logic [7:0] DIR_TICKS = 8'd10
) (
  input  logic       i_cp,
  input  logic       i_clr_n,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic       i_qcc,
  output logic [7:0] o_rs,
  output logic       o_tclr_n,
  output logic       o_ten,
  output logic       o_valve_in,
  output logic       o_valve_out,
  output logic       o_motor_en,
  output logic       o_motor_dir,
  output logic       o_motor_fast,
  output logic       o_buzzer,
  output logic [2:0] o_phase,
  output logic [1:0] o_rinse_left
);

  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_FILL  = 3'd1;
  localparam logic [2:0] PH_WASH  = 3'd2;
  localparam logic [2:0] PH_DRAIN = 3'd3;
  localparam logic [2:0] PH_SPIN  = 3'd4;
  localparam logic [2:0] PH_RINSE = 3'd5;
  localparam logic [2:0] PH_DONE  = 3'd6;

  logic [2:0] r_phase;
  logic [7:0] r_rs;
  logic       r_tclr_n;
  logic       r_paused;
  logic [1:0] r_rinse_left;
  logic       r_wash_pass;
  logic       r_dir;
  logic [7:0] r_dir_cnt;

  logic [2:0] w_phase_nxt;
  logic       w_enter;
  logic       w_expire;
  logic       w_agitate;
  logic [1:0] w_rinse_nxt;
  logic       w_wash_nxt;

  function automatic logic [7:0] f_preset(input logic [2:0] ph);
    case (ph)
      PH_FILL:  f_preset = T_FILL;
      PH_WASH:  f_preset = T_WASH;
      PH_DRAIN: f_preset = T_DRAIN;
      PH_SPIN:  f_preset = T_SPIN;
      PH_RINSE: f_preset = T_RINSE;
      PH_DONE:  f_preset = T_DONE;
      default:  f_preset = 8'd0;
    endcase
  endfunction

  // Expiry is only trusted once the timer has been cleared and is running:
  // not in the clear cycle, not while the timer is frozen, and not on the
  // edge where pause is first seen (pause wins a tie with expiry).
  assign w_expire  = i_qcc && (r_phase != PH_IDLE) && r_tclr_n && !r_paused && !i_pause;
  assign w_agitate = (r_phase == PH_WASH) || (r_phase == PH_RINSE);

  // next-state
  always_comb begin
    w_phase_nxt = r_phase;
    w_enter     = 1'b0;
    w_rinse_nxt = r_rinse_left;
    w_wash_nxt  = r_wash_pass;
    case (r_phase)
      PH_IDLE: begin
        if (i_start && !i_pause) begin
          w_phase_nxt = PH_FILL;
          w_enter     = 1'b1;
        end
      end
      PH_FILL: begin
        if (w_expire) begin
          w_phase_nxt = r_wash_pass ? PH_WASH : PH_RINSE;
          w_enter     = 1'b1;
        end
      end
      PH_WASH: begin
        if (w_expire) begin
          w_phase_nxt = PH_DRAIN;
          w_enter     = 1'b1;
          w_wash_nxt  = 1'b0;
        end
      end
      PH_RINSE: begin
        if (w_expire) begin
          w_phase_nxt = PH_DRAIN;
          w_enter     = 1'b1;
        end
      end
      PH_DRAIN: begin
        if (w_expire) begin
          w_phase_nxt = PH_SPIN;
          w_enter     = 1'b1;
        end
      end
      PH_SPIN: begin
        if (w_expire) begin
          w_enter = 1'b1;
          if (r_rinse_left != 2'd0) begin
            w_rinse_nxt = r_rinse_left - 2'd1;
            w_phase_nxt = PH_FILL;
          end else begin
            w_phase_nxt = PH_DONE;
          end
        end
      end
      PH_DONE: begin
        if (w_expire) begin
          w_phase_nxt = PH_IDLE;
          w_enter     = 1'b1;
          w_rinse_nxt = N_RINSE;
          w_wash_nxt  = 1'b1;
        end
      end
      default: begin
        w_phase_nxt = PH_IDLE;
        w_enter     = 1'b1;
      end
    endcase
  end

  // state register and phase datapath
  always_ff @(posedge i_cp or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_phase      <= PH_IDLE;
      r_rs         <= 8'd0;
      r_tclr_n     <= 1'b1;
      r_paused     <= 1'b0;
      r_rinse_left <= N_RINSE;
      r_wash_pass  <= 1'b1;
      r_dir        <= 1'b0;
      r_dir_cnt    <= 8'd0;
    end else begin
      r_phase      <= w_phase_nxt;
      r_rinse_left <= w_rinse_nxt;
      r_wash_pass  <= w_wash_nxt;
      r_paused     <= i_pause && (w_phase_nxt != PH_IDLE);
      if (w_enter) begin
        // returning to IDLE parks the timer; it does not need a clear pulse
        r_rs      <= f_preset(w_phase_nxt);
        r_tclr_n  <= (w_phase_nxt == PH_IDLE);
        r_dir     <= 1'b0;
        r_dir_cnt <= 8'd0;
      end else begin
        r_tclr_n <= 1'b1;
        if (w_agitate && !i_pause) begin
          if (r_dir_cnt == DIR_TICKS - 8'd1) begin
            r_dir_cnt <= 8'd0;
            r_dir     <= ~r_dir;
          end else begin
            r_dir_cnt <= r_dir_cnt + 8'd1;
          end
        end
      end
    end
  end

  // outputs, decoded from registered state only
  always_comb begin
    o_phase      = r_phase;
    o_rs         = r_rs;
    o_tclr_n     = r_tclr_n;
    o_rinse_left = r_rinse_left;
    o_ten        = (r_phase != PH_IDLE) && !r_paused;
    o_valve_in   = 1'b0;
    o_valve_out  = 1'b0;
    o_motor_en   = 1'b0;
    o_motor_dir  = 1'b0;
    o_motor_fast = 1'b0;
    o_buzzer     = 1'b0;
    if (!r_paused) begin
      case (r_phase)
        PH_FILL:  o_valve_in = 1'b1;
        PH_WASH, PH_RINSE: begin
          o_motor_en  = 1'b1;
          o_motor_dir = r_dir;
        end
        PH_DRAIN: o_valve_out = 1'b1;
        PH_SPIN: begin
          o_valve_out  = 1'b1;
          o_motor_en   = 1'b1;
          o_motor_fast = 1'b1;
        end
        PH_DONE:  o_buzzer = 1'b1;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_wash_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wash_sequencer
// Directed bench for wash_sequencer. Instance a runs one wash pass plus one
// rinse pass with short phase times; instance b has no rinse passes. Inputs
// change 1 time unit after the rising edge and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_wash_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, pause_a = 1'b0, qcc_a = 1'b0;
  logic [7:0] rs_a;
  logic       tclr_a, ten_a, vin_a, vout_a, men_a, mdir_a, mfast_a, buz_a;
  logic [2:0] ph_a;
  logic [1:0] rl_a;

  logic       start_b = 1'b0, pause_b = 1'b0, qcc_b = 1'b0;
  logic [7:0] rs_b;
  logic       tclr_b, ten_b, vin_b, vout_b, men_b, mdir_b, mfast_b, buz_b;
  logic [2:0] ph_b;
  logic [1:0] rl_b;

  int total = 0;
  int bad   = 0;

  wash_sequencer #(
    .T_FILL(8'd3), .T_WASH(8'd4), .T_RINSE(8'd6), .T_DRAIN(8'd2),
    .T_SPIN(8'd2), .T_DONE(8'd5), .N_RINSE(2'd1), .DIR_TICKS(8'd3)
  ) dut_a (
    .i_cp(clk), .i_clr_n(rst_n), .i_start(start_a), .i_pause(pause_a), .i_qcc(qcc_a),
    .o_rs(rs_a), .o_tclr_n(tclr_a), .o_ten(ten_a), .o_valve_in(vin_a),
    .o_valve_out(vout_a), .o_motor_en(men_a), .o_motor_dir(mdir_a),
    .o_motor_fast(mfast_a), .o_buzzer(buz_a), .o_phase(ph_a), .o_rinse_left(rl_a)
  );

  wash_sequencer #(
    .T_FILL(8'd3), .T_WASH(8'd4), .T_RINSE(8'd6), .T_DRAIN(8'd2),
    .T_SPIN(8'd2), .T_DONE(8'd5), .N_RINSE(2'd0), .DIR_TICKS(8'd3)
  ) dut_b (
    .i_cp(clk), .i_clr_n(rst_n), .i_start(start_b), .i_pause(pause_b), .i_qcc(qcc_b),
    .o_rs(rs_b), .o_tclr_n(tclr_b), .o_ten(ten_b), .o_valve_in(vin_b),
    .o_valve_out(vout_b), .o_motor_en(men_b), .o_motor_dir(mdir_b),
    .o_motor_fast(mfast_b), .o_buzzer(buz_b), .o_phase(ph_b), .o_rinse_left(rl_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // leave the clear cycle, then pulse expiry for one edge
  task automatic step_a();
    tick();
    qcc_a = 1'b1;
    tick();
    qcc_a = 1'b0;
  endtask

  task automatic step_b();
    tick();
    qcc_b = 1'b1;
    tick();
    qcc_b = 1'b0;
  endtask

  // full check of instance a on the cycle a phase is entered
  task automatic entry_a(input string tag, input logic [2:0] ph, input logic [7:0] rs,
                         input logic [1:0] rl);
    chk({tag, ".phase"}, 8'(ph_a), 8'(ph));
    chk({tag, ".tclr"},  8'(tclr_a), 8'd0);
    chk({tag, ".rs"},    rs_a, rs);
    chk({tag, ".ten"},   8'(ten_a), 8'd1);
    chk({tag, ".rl"},    8'(rl_a), 8'(rl));
    chk({tag, ".vin"},   8'(vin_a), 8'(ph == 3'd1));
    chk({tag, ".vout"},  8'(vout_a), 8'(ph == 3'd3 || ph == 3'd4));
    chk({tag, ".men"},   8'(men_a), 8'(ph == 3'd2 || ph == 3'd4 || ph == 3'd5));
    chk({tag, ".mfast"}, 8'(mfast_a), 8'(ph == 3'd4));
    chk({tag, ".buz"},   8'(buz_a), 8'(ph == 3'd6));
  endtask

  // n cycles after entry: phase holds and the clear pulse is gone
  task automatic hold_a(input string tag, input int n, input logic [2:0] ph);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, ".hold_phase"}, 8'(ph_a), 8'(ph));
      chk({tag, ".hold_tclr"},  8'(tclr_a), 8'd1);
    end
  endtask

  initial begin
    logic [9:0] dir_exp;
    dir_exp = 10'b1000111000; // bit i = expected direction i cycles after WASH entry

    // ---------------- reset state ----------------
    #12;
    chk("rst.phase", 8'(ph_a), 8'd0);
    chk("rst.rs",    rs_a, 8'd0);
    chk("rst.tclr",  8'(tclr_a), 8'd1);
    chk("rst.ten",   8'(ten_a), 8'd0);
    chk("rst.act",   8'({vin_a, vout_a, men_a, mdir_a, mfast_a, buz_a}), 8'd0);
    chk("rst.rl",    8'(rl_a), 8'd1);
    rst_n = 1'b1;
    tick();

    // ---------------- full program on instance a ----------------
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    entry_a("fill1", 3'd1, 8'd3, 2'd1);
    hold_a("fill1", 2, 3'd1);
    qcc_a = 1'b1; tick(); qcc_a = 1'b0;
    entry_a("wash", 3'd2, 8'd4, 2'd1);

    // direction reversal every 3 cycles, starting at the entry cycle
    chk("dir.c0", 8'(mdir_a), 8'(dir_exp[0]));
    for (int i = 1; i < 10; i++) begin
      tick();
      chk($sformatf("dir.c%0d", i), 8'(mdir_a), 8'(dir_exp[i]));
    end

    // pause rises together with an expiry: pause wins
    pause_a = 1'b1;
    qcc_a   = 1'b1;
    tick();
    qcc_a = 1'b0;
    chk("pause.phase", 8'(ph_a), 8'd2);
    chk("pause.ten",   8'(ten_a), 8'd0);
    chk("pause.act",   8'({vin_a, vout_a, men_a, mdir_a, mfast_a, buz_a}), 8'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pause.hold_phase", 8'(ph_a), 8'd2);
      chk("pause.hold_rs",    rs_a, 8'd4);
      chk("pause.hold_ten",   8'(ten_a), 8'd0);
    end
    pause_a = 1'b0;
    tick();
    chk("resume.phase", 8'(ph_a), 8'd2);
    chk("resume.men",   8'(men_a), 8'd1);
    chk("resume.ten",   8'(ten_a), 8'd1);
    chk("resume.tclr",  8'(tclr_a), 8'd1);
    qcc_a = 1'b1; tick(); qcc_a = 1'b0;
    entry_a("drain1", 3'd3, 8'd2, 2'd1);
    hold_a("drain1", 1, 3'd3);
    qcc_a = 1'b1; tick(); qcc_a = 1'b0;
    entry_a("spin1", 3'd4, 8'd2, 2'd1);
    chk("spin1.mdir", 8'(mdir_a), 8'd0);
    hold_a("spin1", 1, 3'd4);
    qcc_a = 1'b1; tick(); qcc_a = 1'b0;
    entry_a("fill2", 3'd1, 8'd3, 2'd0);
    hold_a("fill2", 1, 3'd1);
    qcc_a = 1'b1; tick(); qcc_a = 1'b0;
    entry_a("rinse", 3'd5, 8'd6, 2'd0);
    chk("rinse.mdir", 8'(mdir_a), 8'd0);
    hold_a("rinse", 1, 3'd5);
    qcc_a = 1'b1; tick(); qcc_a = 1'b0;
    entry_a("drain2", 3'd3, 8'd2, 2'd0);
    hold_a("drain2", 1, 3'd3);

    // expiry held high across an entry: ignored in the clear cycle only
    qcc_a = 1'b1;
    tick();
    entry_a("spin2", 3'd4, 8'd2, 2'd0);
    tick();
    chk("qhold.phase", 8'(ph_a), 8'd4);
    chk("qhold.tclr",  8'(tclr_a), 8'd1);
    tick();
    qcc_a = 1'b0;
    entry_a("done", 3'd6, 8'd5, 2'd0);
    hold_a("done", 1, 3'd6);
    qcc_a = 1'b1; tick(); qcc_a = 1'b0;
    chk("idle.phase", 8'(ph_a), 8'd0);
    chk("idle.ten",   8'(ten_a), 8'd0);
    chk("idle.rs",    rs_a, 8'd0);
    chk("idle.rl",    8'(rl_a), 8'd1);
    chk("idle.act",   8'({vin_a, vout_a, men_a, mdir_a, mfast_a, buz_a}), 8'd0);

    // ---------------- async reset in the second SPIN ----------------
    start_a = 1'b1; tick(); start_a = 1'b0;   // FILL
    step_a();                                  // WASH
    step_a();                                  // DRAIN
    step_a();                                  // SPIN
    step_a();                                  // FILL
    step_a();                                  // RINSE
    step_a();                                  // DRAIN
    step_a();                                  // SPIN
    chk("pre_rst.phase", 8'(ph_a), 8'd4);
    chk("pre_rst.rl",    8'(rl_a), 8'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.phase", 8'(ph_a), 8'd0);
    chk("arst.act",   8'({vin_a, vout_a, men_a, mdir_a, mfast_a, buz_a}), 8'd0);
    chk("arst.ten",   8'(ten_a), 8'd0);
    chk("arst.rl",    8'(rl_a), 8'd1);
    chk("arst.rs",    rs_a, 8'd0);
    #2;
    rst_n = 1'b1;
    tick();
    start_a = 1'b1; tick(); start_a = 1'b0;
    entry_a("rfill", 3'd1, 8'd3, 2'd1);
    step_a();
    entry_a("rwash", 3'd2, 8'd4, 2'd1);

    // ---------------- instance b: no rinse passes ----------------
    pause_b = 1'b1;
    start_b = 1'b1;
    tick();
    chk("b.pause_blocks_start", 8'(ph_b), 8'd0);
    pause_b = 1'b0;
    tick();
    start_b = 1'b0;
    chk("b.fill", 8'(ph_b), 8'd1);
    step_b();
    chk("b.wash", 8'(ph_b), 8'd2);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("b.start_in_wash.phase", 8'(ph_b), 8'd2);
    chk("b.start_in_wash.tclr",  8'(tclr_b), 8'd1);
    qcc_b = 1'b1; tick(); qcc_b = 1'b0;
    chk("b.drain", 8'(ph_b), 8'd3);
    step_b();
    chk("b.spin",     8'(ph_b), 8'd4);
    chk("b.spin.buz", 8'(buz_b), 8'd0);
    step_b();
    chk("b.done",     8'(ph_b), 8'd6);
    chk("b.done.buz", 8'(buz_b), 8'd1);
    chk("b.done.rs",  rs_b, 8'd5);
    chk("b.done.rl",  8'(rl_b), 8'd0);
    tick();
    chk("b.done.buz_hold", 8'(buz_b), 8'd1);
    qcc_b = 1'b1; tick(); qcc_b = 1'b0;
    chk("b.idle",     8'(ph_b), 8'd0);
    chk("b.idle.buz", 8'(buz_b), 8'd0);
    qcc_b = 1'b1;
    tick();
    qcc_b = 1'b0;
    chk("b.qcc_in_idle.phase", 8'(ph_b), 8'd0);
    chk("b.qcc_in_idle.ten",   8'(ten_b), 8'd0);
    chk("b.qcc_in_idle.act",   8'({vin_b, vout_b, men_b, mdir_b, mfast_b, buz_b}), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
